pattern_serializer: RTL and testbench
=====================================

// Module: pattern_serializer
// PURPOSE
//   Parametrised serial pattern generator, successor to the counter/decoder/mux bit-serialiser.
//   Holds DEPTH patterns of WIDTH bits in a writable table, selects one by sel, and shifts it out
//   one bit per clock. Adds start/stop control, one-shot and continuous modes, bit order
//   selection, table writes, and valid/busy/done status. Feeds serial stimulus into downstream labs.
// PARAMETERS
//   WIDTH      8  bits per pattern = bits shifted per frame (>=2)
//   DEPTH      8  number of table entries (<= 2**SEL_W)
//   SEL_W      3  width of sel/wr_addr
//   CNT_W      3  width of bit_idx, 2**CNT_W >= WIDTH
//   LSB_FIRST  1  1: bit 0 is sent first; 0: bit WIDTH-1 is sent first
// PORTS
//   clock     in   1      single clock, all state updates on posedge
//   reset     in   1      synchronous, active-high
//   wr_en     in   1      table write strobe
//   wr_addr   in   SEL_W  table write address (>=DEPTH: write ignored)
//   wr_data   in   WIDTH  table write data
//   sel       in   SEL_W  pattern select, sampled at frame load (>=DEPTH: loads all-zero)
//   start     in   1      start request, honoured only in IDLE
//   mode      in   1      0 one-shot, 1 continuous; sampled with start
//   stop      in   1      abort request, honoured in SHIFT
//   out       out  1      serial data bit (registered)
//   out_valid out  1      out carries a pattern bit this cycle
//   busy      out  1      high in SHIFT
//   done      out  1      one-cycle pulse with the last bit of each completed frame
//   bit_idx   out  CNT_W  frame position of the current bit (0..WIDTH-1, order-independent)
// BEHAVIOUR
//   Reset (sync, highest priority): state=IDLE; out=0, out_valid=0, busy=0, done=0, bit_idx=0.
//     Table entry i reloaded to thermometer value (2**(i+1))-1, saturating at all-ones
//     (WIDTH=8: 01,03,07,0F,1F,3F,7F,FF). Writes in a reset cycle are dropped.
//   Table write: wr_en at posedge writes wr_data to table[wr_addr]; allowed in any state.
//     A write and a load of the same address in one cycle: the load takes wr_data (write-first).
//     A write during SHIFT affects only the next load, never the frame in flight.
//   FSM IDLE -> SHIFT: start=1 in IDLE at edge N. Latch table[sel] into shift register and
//     latch mode. From cycle N+1: out=first bit, out_valid=1, busy=1, bit_idx=0.
//   SHIFT: each edge advances one bit; bit_idx increments 0..WIDTH-1.
//     bit_idx==WIDTH-1: done=1 in the same cycle as that bit.
//       One-shot: next edge -> IDLE; out=0, out_valid=0, busy=0, bit_idx=0.
//       Continuous: next edge reloads table[sel] (sel resampled now), bit_idx=0, no gap cycle.
//   stop=1 in SHIFT: next edge -> IDLE; outputs as idle; no done. stop overrides the
//     completion path, so stop on the last bit suppresses any reload. stop in IDLE is ignored.
//   start in SHIFT is ignored. start and stop together in IDLE: start wins.
//   mode/sel changes mid-frame do not affect the frame in flight.
//   done never asserts outside SHIFT. busy==out_valid at all times.
// TESTING
//   1. Reset, then sel=2, mode=0, start 1 cycle -> out=1,1,1,0,0,0,0,0 over 8 cycles;
//      done only on 8th; then out_valid=0.
//   2. LSB_FIRST=0, sel=4 (1F), one-shot -> out=0,0,0,1,1,1,1,1; bit_idx 0..7.
//   3. Continuous, sel=0 for frame 1, set sel=7 mid-frame -> frame 1=1,0,0,0,0,0,0,0;
//      frame 2=eight 1s with no gap; done pulses at cycles 8 and 16.
//   4. wr_en addr 5 data A5 in the same cycle as start sel=5 -> A5 sent LSB-first:
//      1,0,1,0,0,1,0,1.
//   5. stop at bit_idx=3 -> next cycle out_valid=0, busy=0, done never pulses;
//      a new start works normally.
//   6. reset asserted mid-frame after writing 00 to entry 1 -> outputs idle next cycle;
//      entry 1 reads back as 03 on a fresh one-shot.

Source files
------------

// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - table-driven serial pattern generator
// Shifts a WIDTH-bit table entry out one bit per clock, in one-shot or continuous mode.
module pattern_serializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int SEL_W     = 3,
  parameter int CNT_W     = 3,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [SEL_W-1:0] sel,
  input  logic             start,
  input  logic             mode,
  input  logic             stop,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_idx
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [SEL_W:0]   DEPTH_L  = (SEL_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  // Reset contents: entry idx holds its low idx+1 bits set, saturating at all-ones.
  function automatic logic [WIDTH-1:0] therm(input int idx);
    logic [WIDTH-1:0] v;
    for (int j = 0; j < WIDTH; j++) begin
      v[j] = (j <= idx);
    end
    return v;
  endfunction

  logic [WIDTH-1:0] tbl [DEPTH];
  state_t           state, state_d;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic             wr_ok, sel_ok, last_bit;
  logic [WIDTH-1:0] load_pat;
  logic             do_load, do_shift, do_clear;

  assign wr_ok    = wr_en && ({1'b0, wr_addr} < DEPTH_L);
  assign sel_ok   = ({1'b0, sel} < DEPTH_L);
  assign last_bit = (cnt == LAST_IDX);

  // Write-first: a same-cycle write to the selected entry is what gets loaded.
  always_comb begin
    load_pat = '0;
    if (sel_ok) begin
      if (wr_ok && (wr_addr == sel)) begin
        load_pat = wr_data;
      end else begin
        load_pat = tbl[sel];
      end
    end
  end

  always_comb begin
    state_d  = state;
    do_load  = 1'b0;
    do_shift = 1'b0;
    do_clear = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          do_load = 1'b1;
        end
      end
      SHIFT: begin
        // stop outranks frame completion, so it also cancels a continuous reload
        if (stop) begin
          state_d  = IDLE;
          do_clear = 1'b1;
        end else if (last_bit) begin
          if (mode_q) begin
            do_load = 1'b1;
          end else begin
            state_d  = IDLE;
            do_clear = 1'b1;
          end
        end else begin
          do_shift = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        do_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= therm(i);
      end
    end else if (wr_ok) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      state <= state_d;
      if (do_load) begin
        sreg <= load_pat;
        cnt  <= '0;
        if (state == IDLE) begin
          mode_q <= mode;
        end
      end else if (do_shift) begin
        sreg <= LSB_FIRST ? (sreg >> 1) : (sreg << 1);
        cnt  <= cnt + CNT_W'(1);
      end else if (do_clear) begin
        sreg <= '0;
        cnt  <= '0;
      end
    end
  end

  // sreg is cleared whenever the FSM is idle, so out idles low straight from the flop.
  assign out       = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
  assign busy      = (state == SHIFT);
  assign out_valid = busy;
  assign done      = busy && last_bit;
  assign bit_idx   = cnt;

endmodule

// File: tb/tb_pattern_serializer.sv
// tb/tb_pattern_serializer.sv - randomized check of pattern_serializer against a frame-level model
module tb_pattern_serializer;
  localparam int W  = 8;
  localparam int D  = 6;
  localparam int SW = 3;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0, start = 1'b0, mode = 1'b0, stop = 1'b0;
  logic [SW-1:0] wr_addr = '0, sel = '0;
  logic [W-1:0]  wr_data = '0;
  logic          out_l, valid_l, busy_l, done_l;
  logic          out_m, valid_m, busy_m, done_m;
  logic [CW-1:0] idx_l, idx_m;

  pattern_serializer #(.WIDTH(W), .DEPTH(D), .SEL_W(SW), .CNT_W(CW), .LSB_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel(sel), .start(start), .mode(mode), .stop(stop), .out(out_l), .out_valid(valid_l),
    .busy(busy_l), .done(done_l), .bit_idx(idx_l));

  pattern_serializer #(.WIDTH(W), .DEPTH(D), .SEL_W(SW), .CNT_W(CW), .LSB_FIRST(1'b0)) dut_m (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel(sel), .start(start), .mode(mode), .stop(stop), .out(out_m), .out_valid(valid_m),
    .busy(busy_m), .done(done_m), .bit_idx(idx_m));

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame-level model: table contents, active frame pattern and position within it.
  bit [W-1:0] m_tbl [D];
  bit         m_act, m_mode;
  bit [W-1:0] m_pat;
  int         m_pos;

  function automatic bit [W-1:0] therm(input int i);
    bit [W-1:0] v;
    for (int j = 0; j < W; j++) v[j] = (j <= i);
    return v;
  endfunction

  task automatic model_edge();
    bit [W-1:0] nt [D];
    bit [W-1:0] ld;
    if (reset) begin
      m_act = 0;
      m_pos = 0;
      for (int i = 0; i < D; i++) m_tbl[i] = therm(i);
      return;
    end
    nt = m_tbl;
    if (wr_en && int'(wr_addr) < D) nt[wr_addr] = wr_data;
    ld = (int'(sel) < D) ? nt[sel] : '0;
    if (!m_act) begin
      if (start) begin
        m_act  = 1;
        m_pat  = ld;
        m_pos  = 0;
        m_mode = mode;
      end
    end else if (stop) begin
      m_act = 0;
    end else if (m_pos == W - 1) begin
      if (m_mode) begin
        m_pat = ld;
        m_pos = 0;
      end else begin
        m_act = 0;
      end
    end else begin
      m_pos++;
    end
    m_tbl = nt;
  endtask

  task automatic check_outs();
    bit el, em, ed;
    int ei;
    el = m_act ? m_pat[m_pos] : 1'b0;
    em = m_act ? m_pat[W-1-m_pos] : 1'b0;
    ed = m_act && (m_pos == W - 1);
    ei = m_act ? m_pos : 0;
    check("out_lsb",   32'(out_l),   32'(el));
    check("out_msb",   32'(out_m),   32'(em));
    check("out_valid", 32'(valid_l), 32'(m_act));
    check("busy",      32'(busy_l),  32'(m_act));
    check("done",      32'(done_l),  32'(ed));
    check("bit_idx",   32'(idx_l),   32'(ei));
    check("valid_m",   32'(valid_m), 32'(m_act));
    check("done_m",    32'(done_m),  32'(ed));
    check("bit_idx_m", 32'(idx_m),   32'(ei));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  bit [7:0] pat;
  bit [7:0] rx;
  int       dcount;

  initial begin
    run(2);
    check("reset_valid", 32'(valid_l), 32'(0));
    check("reset_out",   32'(out_l),   32'(0));
    reset = 1'b0;
    run(1);

    // one-shot sel=2, LSB first: 07 -> 1,1,1,0,0,0,0,0
    sel = 3'd2; mode = 1'b0; start = 1'b1;
    pat = 8'h07;
    for (int k = 0; k < 8; k++) begin
      step();
      start = 1'b0;
      check("t1_out",  32'(out_l),  32'(pat[k]));
      check("t1_done", 32'(done_l), 32'(k == 7));
    end
    step();
    check("t1_idle", 32'(valid_l), 32'(0));

    // one-shot sel=4 (1F) on the MSB-first instance
    sel = 3'd4; start = 1'b1;
    pat = 8'h1F;
    for (int k = 0; k < 8; k++) begin
      step();
      start = 1'b0;
      check("t2_out", 32'(out_m), 32'(pat[7-k]));
      check("t2_idx", 32'(idx_m), 32'(k));
    end
    run(2);

    // continuous: sel 0, then 5 mid-frame, then out-of-range 7 (loads zero)
    sel = 3'd0; mode = 1'b1; start = 1'b1;
    dcount = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      start = 1'b0;
      if (k == 3)  sel = 3'd5;
      if (k == 12) sel = 3'd7;
      if (done_l) dcount++;
    end
    check("t3_dones", 32'(dcount), 32'(3));
    stop = 1'b1; step(); stop = 1'b0;
    check("t3_stopped", 32'(busy_l), 32'(0));

    // write-first: write A5 to entry 5 while starting on it
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hA5; sel = 3'd5; mode = 1'b0; start = 1'b1;
    rx = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      wr_en = 1'b0; start = 1'b0;
      rx[k] = out_l;
    end
    check("t4_frame", 32'(rx), 32'(8'hA5));
    run(2);

    // stop at bit 3, then a clean restart
    sel = 3'd3; start = 1'b1;
    step(); start = 1'b0;
    run(3);
    check("t5_idx3", 32'(idx_l), 32'(3));
    stop = 1'b1; step(); stop = 1'b0;
    check("t5_stop_valid", 32'(valid_l), 32'(0));
    check("t5_stop_done",  32'(done_l),  32'(0));
    start = 1'b1; step(); start = 1'b0;
    run(9);

    // reset mid-frame restores entry 1 to its thermometer value
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h00; step(); wr_en = 1'b0;
    sel = 3'd1; mode = 1'b1; start = 1'b1; step(); start = 1'b0;
    run(3);
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_rst_busy", 32'(busy_l), 32'(0));
    mode = 1'b0; start = 1'b1;
    rx = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      start = 1'b0;
      rx[k] = out_l;
    end
    check("t6_frame", 32'(rx), 32'(8'h03));
    run(2);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset   = ($urandom_range(0, 299) == 0);
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_addr = SW'($urandom_range(0, 7));
      wr_data = W'($urandom);
      sel     = SW'($urandom_range(0, 7));
      start   = ($urandom_range(0, 3) == 0);
      mode    = 1'($urandom);
      stop    = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
